cam_match_serializer: RTL

Downstream stage of the 16-entry content-addressable memory. It consumes the CAM's 16-bit match vector, `found_addr`, in which one bit per entry is set when that entry matched. It captures one vector per `start` and emits the indices of all set bits, lowest first, one per handshake on a valid/ready stream. It also reports the total match count and a one-cycle "no match" pulse. The upstream controller pulses `start` in the cycle after it presents `content`, which is when `found_addr` is valid.

---
 rtl/cam_match_serializer_if.sv | 26 ++
 rtl/cam_match_serializer.sv | 80 ++++++++
 2 files changed

// File: rtl/cam_match_serializer_if.sv
// Handshake and data bundle between the CAM front end, the match serializer
// and the downstream index consumer.
interface cam_match_serializer_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
);
  logic          start;
  logic [N-1:0]  match_vec;
  logic          busy;
  logic          idx_valid;
  logic [AW-1:0] idx;
  logic          idx_ready;
  logic          last;
  logic [AW:0]   match_count;
  logic          none;

  modport master (
    output start, match_vec, idx_ready,
    input  busy, idx_valid, idx, last, match_count, none
  );

  modport slave (
    input  start, match_vec, idx_ready,
    output busy, idx_valid, idx, last, match_count, none
  );
endinterface

// File: rtl/cam_match_serializer.sv
// Captures one CAM match vector per start and streams the indices of its set
// bits, lowest first, over a valid/ready handshake.
module cam_match_serializer #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  cam_match_serializer_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e        state_q;
  logic [N-1:0]  pending_q;
  logic [N-1:0]  pending_d;
  logic [AW:0]   match_count_q;
  logic          none_q;

  logic [AW-1:0] low_idx;
  logic [AW:0]   popcnt;
  logic          one_left;

  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[N-1-i]) low_idx = AW'(N-1-i);
    end
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      popcnt = popcnt + (AW+1)'(bus.match_vec[i]);
    end
  end

  // x & (x-1) drops the lowest set bit, i.e. the index currently presented.
  assign pending_d = pending_q & (pending_q - N'(1));
  assign one_left  = (pending_q != '0) && (pending_d == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      match_count_q <= '0;
      none_q        <= 1'b0;
    end else begin
      none_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            match_count_q <= popcnt;
            if (bus.match_vec != '0) begin
              pending_q <= bus.match_vec;
              state_q   <= EMIT;
            end else begin
              none_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.idx_ready) begin
            pending_q <= pending_d;
            if (one_left) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_q == EMIT);
  assign bus.idx_valid   = (state_q == EMIT);
  assign bus.idx         = (state_q == EMIT) ? low_idx : '0;
  assign bus.last        = (state_q == EMIT) && one_left;
  assign bus.match_count = match_count_q;
  assign bus.none        = none_q;

endmodule
